// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI coprocessor interface: opcode, latched command and sequencer states.
package arm7tdmi_pkg;

    typedef enum logic [2:0] {
        CP_NONE = 3'd0,
        CP_CDP  = 3'd1,
        CP_MRC  = 3'd2,
        CP_MCR  = 3'd3,
        CP_LDC  = 3'd4,
        CP_STC  = 3'd5
    } cp_op_t;

    typedef struct packed {
        cp_op_t     op;
        logic [3:0] num;
        logic [3:0] crd;
        logic [3:0] crn;
        logic [2:0] opcode1;
        logic [2:0] opcode2;
        logic       load;
    } cp_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_XFER_REG,
        ST_XFER_MEM,
        ST_UNDEF,
        ST_DONE
    } cp_if_state_t;

    localparam int CP_WORD_BYTES = 4;

    // Byte address of word idx of a transfer; wraps at 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(CP_WORD_BYTES);
    endfunction

endpackage

// File: rtl/arm7tdmi_cp_xfer.sv
// LDC/STC word sequencer: word counter, address generation and memory request/ack handshake.
module arm7tdmi_cp_xfer
    import arm7tdmi_pkg::*;
#(
    parameter int MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_active,
    input  logic        i_load,
    input  logic [31:0] i_base_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_cp_rdata,
    input  logic        i_cp_last,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [31:0] o_cp_wdata,
    output logic        o_cp_wvalid,
    output logic        o_finish
);

    localparam int CW = $clog2(MAX_WORDS) + 1;

    logic [CW-1:0] r_count;
    logic          w_ack;
    logic          w_store;

    assign w_ack   = i_active & i_mem_ack;
    assign w_store = i_active & ~i_load;

    // Counter idles at zero so every transfer starts from the base address.
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_count <= '0;
        end else if (w_ack) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_mem_req   = i_active;
    assign o_mem_we    = w_store;
    assign o_mem_addr  = i_active ? word_addr(i_base_addr, 32'(r_count)) : '0;
    assign o_mem_wdata = w_store ? i_cp_rdata : '0;
    assign o_cp_wvalid = w_ack & i_load;
    assign o_cp_wdata  = o_cp_wvalid ? i_mem_rdata : '0;
    assign o_finish    = w_ack & (i_cp_last | (r_count == CW'(MAX_WORDS - 1)));

endmodule

// File: rtl/arm7tdmi_cp_if.sv
// ARM7TDMI coprocessor interface sequencer (CPI/CPA/CPB handshake, MRC/MCR, LDC/STC).
// Optional busy-wait watchdog enabled by defining CP_TIMEOUT_EN.
module arm7tdmi_cp_if
    import arm7tdmi_pkg::*;
#(
    parameter int MAX_WORDS    = 16,
    parameter int BUSY_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp_valid,
    input  cp_op_t      cp_op,
    input  logic [3:0]  cp_num,
    input  logic [3:0]  cp_crd,
    input  logic [3:0]  cp_crn,
    input  logic [2:0]  cp_opcode1,
    input  logic [2:0]  cp_opcode2,
    input  logic        cp_load,
    input  logic [3:0]  arm_rd,
    input  logic [31:0] arm_rd_data,
    input  logic [31:0] base_addr,
    input  logic        irq_pending,
    input  logic        flush,
    output logic        cpi,
    output cp_cmd_t     cp_cmd,
    input  logic        cpa,
    input  logic        cpb,
    output logic [31:0] cp_wdata,
    output logic        cp_wvalid,
    input  logic [31:0] cp_rdata,
    input  logic        cp_last,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flags_we,
    output logic [3:0]  flags_nzcv,
    output logic        stall,
    output logic        undef,
    output logic        done
);

    cp_if_state_t r_state;
    cp_cmd_t      r_cmd;
    logic         r_cpi;
    logic         r_undef;
    logic         r_done;
    cp_cmd_t      w_cmd_in;
    logic         w_finish;
    logic         w_x_wvalid;
    logic [31:0]  w_x_wdata;
    logic         w_xreg_mrc;
    logic         w_xreg_mcr;

`ifdef CP_TIMEOUT_EN
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    logic [TW-1:0] r_tmo;
`endif

    assign w_cmd_in = '{op: cp_op, num: cp_num, crd: cp_crd, crn: cp_crn,
                        opcode1: cp_opcode1, opcode2: cp_opcode2, load: cp_load};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_cpi   <= 1'b0;
            r_undef <= 1'b0;
            r_done  <= 1'b0;
`ifdef CP_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            r_cpi   <= 1'b0;
            r_undef <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cp_valid && !flush) begin
                        r_cmd   <= w_cmd_in;
                        r_state <= ST_ISSUE;
                        r_cpi   <= 1'b1;
                    end
                end
                ST_ISSUE, ST_BUSY: begin
`ifdef CP_TIMEOUT_EN
                    r_tmo <= (r_state == ST_BUSY) ? r_tmo + 1'b1 : '0;
`endif
                    // An abandoned busy-wait is silently re-issued by the core later.
                    if (flush || (r_state == ST_BUSY && irq_pending)) begin
                        r_state <= ST_IDLE;
                    end else if (cpa) begin
                        r_state <= ST_UNDEF;
                        r_undef <= 1'b1;
                    end else if (!cpb) begin
                        case (r_cmd.op)
                            CP_MRC, CP_MCR: r_state <= ST_XFER_REG;
                            CP_LDC, CP_STC: r_state <= ST_XFER_MEM;
                            default: begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        endcase
`ifdef CP_TIMEOUT_EN
                    end else if (r_state == ST_BUSY && r_tmo == TW'(BUSY_TIMEOUT - 1)) begin
                        r_state <= ST_UNDEF;
                        r_undef <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_BUSY;
                        r_cpi   <= 1'b1;
                    end
                end
                ST_XFER_REG: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_XFER_MEM: begin
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    arm7tdmi_cp_xfer #(
        .MAX_WORDS (MAX_WORDS)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state == ST_XFER_MEM),
        .i_load      (r_cmd.load),
        .i_base_addr (base_addr),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .i_cp_rdata  (cp_rdata),
        .i_cp_last   (cp_last),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cp_wdata  (w_x_wdata),
        .o_cp_wvalid (w_x_wvalid),
        .o_finish    (w_finish)
    );

    assign w_xreg_mrc = (r_state == ST_XFER_REG) && (r_cmd.op == CP_MRC);
    assign w_xreg_mcr = (r_state == ST_XFER_REG) && (r_cmd.op == CP_MCR);

    // MRC to R15 updates NZCV instead of the register file.
    assign rf_we      = w_xreg_mrc && (arm_rd != 4'hF);
    assign rf_waddr   = rf_we ? arm_rd : '0;
    assign rf_wdata   = rf_we ? cp_rdata : '0;
    assign flags_we   = w_xreg_mrc && (arm_rd == 4'hF);
    assign flags_nzcv = flags_we ? cp_rdata[31:28] : '0;

    assign cp_wvalid  = w_xreg_mcr | w_x_wvalid;
    assign cp_wdata   = w_xreg_mcr ? arm_rd_data : w_x_wdata;

    assign cpi    = r_cpi;
    assign undef  = r_undef;
    assign done   = r_done;
    assign cp_cmd = r_cmd;
    assign stall  = ((r_state == ST_IDLE) && cp_valid) ||
                    ((r_state != ST_IDLE) && (r_state != ST_DONE));

endmodule

// File: tb/tb_arm7tdmi_cp_if.sv
// Randomized self-checking bench for arm7tdmi_cp_if against a transaction-level handshake model.
module tb_arm7tdmi_cp_if;
    import arm7tdmi_pkg::*;

    localparam int MAXW = 16;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp_valid;
    cp_op_t      cp_op;
    logic [3:0]  cp_num, cp_crd, cp_crn;
    logic [2:0]  cp_opcode1, cp_opcode2;
    logic        cp_load;
    logic [3:0]  arm_rd;
    logic [31:0] arm_rd_data, base_addr;
    logic        irq_pending, flush;
    logic        cpi;
    cp_cmd_t     cp_cmd;
    logic        cpa, cpb;
    logic [31:0] cp_wdata;
    logic        cp_wvalid;
    logic [31:0] cp_rdata;
    logic        cp_last;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flags_we;
    logic [3:0]  flags_nzcv;
    logic        stall, undef, done;

    int n_checks = 0;
    int n_fail   = 0;

    arm7tdmi_cp_if #(.MAX_WORDS(MAXW), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cp_valid(cp_valid), .cp_op(cp_op), .cp_num(cp_num),
        .cp_crd(cp_crd), .cp_crn(cp_crn), .cp_opcode1(cp_opcode1), .cp_opcode2(cp_opcode2),
        .cp_load(cp_load), .arm_rd(arm_rd), .arm_rd_data(arm_rd_data), .base_addr(base_addr),
        .irq_pending(irq_pending), .flush(flush), .cpi(cpi), .cp_cmd(cp_cmd), .cpa(cpa),
        .cpb(cpb), .cp_wdata(cp_wdata), .cp_wvalid(cp_wvalid), .cp_rdata(cp_rdata),
        .cp_last(cp_last), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags_we(flags_we), .flags_nzcv(flags_nzcv),
        .stall(stall), .undef(undef), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_ctrl(input string tag, input bit e_cpi, input bit e_stall,
                              input bit e_undef, input bit e_done);
        check_eq({tag, ".cpi"},   cpi,   e_cpi);
        check_eq({tag, ".stall"}, stall, e_stall);
        check_eq({tag, ".undef"}, undef, e_undef);
        check_eq({tag, ".done"},  done,  e_done);
    endtask

    task automatic quiet_inputs();
        cp_valid = 0; flush = 0; irq_pending = 0; cpa = 0; cpb = 0;
        mem_ack = 0; cp_last = 0;
    endtask

    task automatic present(input cp_op_t op, input logic [3:0] rd, input logic [31:0] base);
        cp_valid    = 1;
        cp_op       = op;
        cp_num      = 4'($urandom);
        cp_crd      = 4'($urandom);
        cp_crn      = 4'($urandom);
        cp_opcode1  = 3'($urandom);
        cp_opcode2  = 3'($urandom);
        cp_load     = (op == CP_LDC);
        arm_rd      = rd;
        arm_rd_data = $urandom;
        base_addr   = base;
    endtask

    // One instruction, modelled as: accept, ISSUE, busy_n busy-wait cycles, transfer phase, DONE.
    task automatic run_op(input cp_op_t op, input logic [3:0] rd, input logic [31:0] rdata,
                          input int busy_n, input bit absent, input int nwords,
                          input bit use_last, input int ack_dly, input int irq_at,
                          input logic [31:0] base);
        logic [21:0] exp_cmd;
        logic [31:0] d_mem, d_cp;
        bit          load;
        load = (op == CP_LDC);
        present(op, rd, base);
        exp_cmd = {op, cp_num, cp_crd, cp_crn, cp_opcode1, cp_opcode2, cp_load};
        #1; check_ctrl("accept", 0, 1, 0, 0);
        next_cycle();
        cp_valid = 0; cpa = absent; cpb = (busy_n > 0) && !absent;
        #1; check_ctrl("issue", 1, 1, 0, 0);
        check_eq("cmd", 32'(cp_cmd), 32'(exp_cmd));
        if (absent) begin
            next_cycle(); cpa = 0;
            #1; check_ctrl("undef", 0, 1, 1, 0);
            check_eq("undef.rf_we", rf_we, 0);
            check_eq("undef.mem_req", mem_req, 0);
            next_cycle();
            #1; check_ctrl("post_undef", 0, 0, 0, 0);
            return;
        end
        for (int b = 0; b < busy_n; b++) begin
            next_cycle();
            cpb = (b < busy_n - 1);
            irq_pending = (b == irq_at);
            #1; check_ctrl("busy", 1, 1, 0, 0);
            if (b == irq_at) begin
                next_cycle(); irq_pending = 0; cpb = 0;
                #1; check_ctrl("irq_abort", 0, 0, 0, 0);
                return;
            end
        end
        next_cycle(); cpb = 0;
        if (op == CP_MRC || op == CP_MCR) begin
            cp_rdata = rdata;
            #1; check_ctrl("xreg", 0, 1, 0, 0);
            if (op == CP_MRC && rd != 4'hF) begin
                check_eq("mrc.rf_we", rf_we, 1);
                check_eq("mrc.rf_waddr", rf_waddr, rd);
                check_eq("mrc.rf_wdata", rf_wdata, rdata);
                check_eq("mrc.flags_we", flags_we, 0);
            end else if (op == CP_MRC) begin
                check_eq("mrc15.rf_we", rf_we, 0);
                check_eq("mrc15.flags_we", flags_we, 1);
                check_eq("mrc15.nzcv", flags_nzcv, rdata >> 28);
            end else begin
                check_eq("mcr.cp_wvalid", cp_wvalid, 1);
                check_eq("mcr.cp_wdata", cp_wdata, arm_rd_data);
                check_eq("mcr.rf_we", rf_we, 0);
            end
            next_cycle();
        end else if (op == CP_LDC || op == CP_STC) begin
            for (int w = 0; w < nwords; w++) begin
                for (int d = 0; d < ack_dly; d++) begin
                    #1;
                    check_eq("mem.wait_req", mem_req, 1);
                    check_eq("mem.wait_addr", mem_addr, base + 32'(4 * w));
                    check_eq("mem.wait_wvalid", cp_wvalid, 0);
                    next_cycle();
                end
                d_mem = $urandom; d_cp = $urandom;
                mem_ack = 1; mem_rdata = d_mem; cp_rdata = d_cp;
                cp_last = use_last && (w == nwords - 1);
                #1;
                check_eq("mem.req", mem_req, 1);
                check_eq("mem.addr", mem_addr, base + 32'(4 * w));
                check_eq("mem.we", mem_we, !load);
                check_eq("mem.stall", stall, 1);
                if (load) begin
                    check_eq("ldc.wvalid", cp_wvalid, 1);
                    check_eq("ldc.wdata", cp_wdata, d_mem);
                end else begin
                    check_eq("stc.wdata", mem_wdata, d_cp);
                    check_eq("stc.wvalid", cp_wvalid, 0);
                end
                next_cycle();
                mem_ack = 0; cp_last = 0;
            end
        end
        cp_valid = 1;
        #1; check_ctrl("done", 0, 0, 0, 1);
        check_eq("done.mem_req", mem_req, 0);
        check_eq("done.rf_we", rf_we, 0);
        next_cycle(); cp_valid = 0;
        #1; check_ctrl("idle_after_done", 0, 0, 0, 0);
    endtask

    initial begin
        cp_op = CP_NONE; cp_num = 0; cp_crd = 0; cp_crn = 0; cp_opcode1 = 0; cp_opcode2 = 0;
        cp_load = 0; arm_rd = 0; arm_rd_data = 0; base_addr = 0; cp_rdata = 0; mem_rdata = 0;
        quiet_inputs();
        rst = 1;
        repeat (3) next_cycle();
        rst = 0;
        #1;
        check_ctrl("reset", 0, 0, 0, 0);
        check_eq("reset.cp_cmd", 32'(cp_cmd), 0);
        check_eq("reset.mem_req", mem_req, 0);
        check_eq("reset.mem_we", mem_we, 0);
        check_eq("reset.mem_addr", mem_addr, 0);
        check_eq("reset.mem_wdata", mem_wdata, 0);
        check_eq("reset.cp_wvalid", cp_wvalid, 0);
        check_eq("reset.cp_wdata", cp_wdata, 0);
        check_eq("reset.rf", {rf_we, rf_waddr}, 0);
        check_eq("reset.rf_wdata", rf_wdata, 0);
        check_eq("reset.flags", {flags_we, flags_nzcv}, 0);
        next_cycle();

        // Directed cases from the handshake description.
        run_op(CP_MRC, 4'd0,  32'h41007700, 0, 0, 0, 0, 0, -1, 0);
        run_op(CP_MCR, 4'd2,  32'h0,        3, 0, 0, 0, 0, -1, 0);
        run_op(CP_LDC, 4'd0,  32'h0,        0, 0, 3, 1, 1, -1, 32'h1010);
        run_op(CP_CDP, 4'd0,  32'h0,        0, 1, 0, 0, 0, -1, 0);
        run_op(CP_MRC, 4'd15, 32'hA0000000, 0, 0, 0, 0, 0, -1, 0);
        run_op(CP_CDP, 4'd0,  32'h0,        7, 0, 0, 0, 0, 5, 0);
        run_op(CP_STC, 4'd0,  32'h0,        1, 0, MAXW, 0, 0, -1, 32'hFFFF_FFF0);
        run_op(CP_LDC, 4'd0,  32'h0,        0, 0, 2, 1, 0, -1, 32'hFFFF_FFFC);

        // Flush while presenting in IDLE: nothing accepted.
        present(CP_CDP, 0, 0);
        flush = 1;
        next_cycle(); cp_valid = 0; flush = 0;
        #1; check_ctrl("flush_idle", 0, 0, 0, 0);
        next_cycle();

        // Flush during ISSUE: discarded, no cpi afterwards.
        present(CP_MCR, 3, 0);
        next_cycle(); cp_valid = 0; flush = 1;
        #1; check_ctrl("flush_issue.issue", 1, 1, 0, 0);
        next_cycle(); flush = 0;
        #1; check_ctrl("flush_issue.after", 0, 0, 0, 0);
        next_cycle();
        #1; check_eq("flush_issue.no_done", done, 0);

`ifdef CP_TIMEOUT_EN
        present(CP_CDP, 0, 0);
        next_cycle(); cp_valid = 0; cpb = 1;
        for (int b = 0; b < TMO; b++) begin
            next_cycle();
            #1; check_ctrl("tmo.busy", 1, 1, 0, 0);
        end
        next_cycle();
        #1; check_ctrl("tmo.undef", 0, 1, 1, 0);
        next_cycle(); cpb = 0;
        #1; check_ctrl("tmo.idle", 0, 0, 0, 0);
`else
        present(CP_CDP, 0, 0);
        next_cycle(); cp_valid = 0; cpb = 1;
        for (int b = 0; b < 3 * TMO; b++) begin
            next_cycle();
            #1; check_ctrl("hold.busy", 1, 1, 0, 0);
        end
        next_cycle(); flush = 1;
        #1; check_ctrl("hold.flush_cycle", 1, 1, 0, 0);
        next_cycle(); flush = 0; cpb = 0;
        #1; check_ctrl("hold.idle", 0, 0, 0, 0);
`endif
        next_cycle();

        // Reset in the middle of a memory transfer drops the request.
        present(CP_STC, 0, 32'h2000);
        next_cycle(); cp_valid = 0;
        next_cycle();
        #1; check_eq("midrst.req_before", mem_req, 1);
        rst = 1;
        next_cycle(); rst = 0;
        #1;
        check_ctrl("midrst", 0, 0, 0, 0);
        check_eq("midrst.mem_req", mem_req, 0);
        check_eq("midrst.cp_cmd", 32'(cp_cmd), 0);
        next_cycle();

        // Randomized instruction stream.
        for (int t = 0; t < 60; t++) begin
            cp_op_t op;
            int     busy_n, irq_at, nwords, dly;
            bit     absent, use_last;
            op       = cp_op_t'($urandom_range(1, 5));
            absent   = ($urandom_range(0, 7) == 0);
            busy_n   = $urandom_range(0, 3);
            irq_at   = (busy_n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(0, busy_n - 2) : -1;
            use_last = ($urandom_range(0, 9) != 0);
            nwords   = use_last ? $urandom_range(1, 5) : MAXW;
            dly      = $urandom_range(0, 2);
            run_op(op, 4'($urandom_range(0, 15)), $urandom, busy_n, absent, nwords, use_last,
                   dly, irq_at, $urandom & 32'hFFFF_FFFC);
            quiet_inputs();
            if ($urandom_range(0, 1) == 1) next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
